pio_dtack_gen: RTL and testbench

Bus-cycle responder for the peripheral I/O window: it closes every host access that the PIO strobe decoder opens. Per sub-region it counts wait states, or waits on a peripheral ready line, then asserts DTACK to the host. It holds DTACK until address strobe negates and, when enabled, raises a bus error on unmapped regions or timeout. It sits between the host bus interface and the PIO strobe decoder, on the same `cs`/`adm[14:12]` qualification.

---
 rtl/pio_dtack_gen_if.sv | 24 ++
 rtl/pio_dtack_gen.sv | 148 ++++++++++++++
 tb/tb_pio_dtack_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pio_dtack_gen_if.sv
// Host-side handshake bundle between the PIO bus interface and the DTACK responder.
// The slave modport is the responder's view; the master modport is the host/decoder side.
interface pio_dtack_gen_if;
  logic        cs;
  logic        as_n;
  logic        rw_n;
  logic [14:12] adm;
  logic        usb_ready;
  logic        dtack_n;
  logic        berr_n;
  logic        busy;
  logic        timeout_flag;
  logic        cyc_rw_n;   // direction latched at the start of the current/last cycle

  modport slave (
    input  cs, as_n, rw_n, adm, usb_ready,
    output dtack_n, berr_n, busy, timeout_flag, cyc_rw_n
  );

  modport master (
    output cs, as_n, rw_n, adm, usb_ready,
    input  dtack_n, berr_n, busy, timeout_flag, cyc_rw_n
  );
endinterface

// File: rtl/pio_dtack_gen.sv
// Bus-cycle responder for the PIO window: per-region wait states / USB ready, then DTACK.
// Define PIO_BERR_EN to turn timeouts into BERR instead of a forced DTACK.
module pio_dtack_gen #(
  parameter int unsigned WS_R0     = 1,
  parameter int unsigned WS_R1     = 3,
  parameter int unsigned WS_R3     = 0,
  parameter int unsigned USB_SETUP = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic             clk,
  input logic             reset_n,
  pio_dtack_gen_if.slave  bus
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] WS_R0_C     = CW'(WS_R0);
  localparam logic [CW-1:0] WS_R1_C     = CW'(WS_R1);
  localparam logic [CW-1:0] WS_R3_C     = CW'(WS_R3);
  localparam logic [CW-1:0] USB_SETUP_C = CW'(USB_SETUP);
  localparam logic [CW-1:0] TIMEOUT_C   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    region_q, region_d;
  logic          rw_q, rw_d;
  logic          dtack_q, dtack_d;
  logic          busy_q, busy_d;
  logic          tflag_q, tflag_d;
`ifdef PIO_BERR_EN
  logic          berr_q, berr_d;
`endif

  logic [CW-1:0] wait_c;
  logic          fixed_c;
  logic          usb_c;
  logic          term_c;
  logic          timeout_c;

  // Wait requirement of the latched region; regions 4-7 have none and only time out.
  always_comb begin
    wait_c  = '0;
    fixed_c = 1'b0;
    usb_c   = 1'b0;
    case (region_q)
      3'd0:    begin wait_c = WS_R0_C;     fixed_c = 1'b1; end
      3'd1:    begin wait_c = WS_R1_C;     fixed_c = 1'b1; end
      3'd2:    begin wait_c = USB_SETUP_C; usb_c   = 1'b1; end
      3'd3:    begin wait_c = WS_R3_C;     fixed_c = 1'b1; end
      default: ;
    endcase
  end

  assign term_c    = (count_q >= wait_c) && (fixed_c || (usb_c && bus.usb_ready));
  assign timeout_c = (count_q == TIMEOUT_C) && !term_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      region_q <= '0;
      rw_q     <= 1'b1;
      dtack_q  <= 1'b1;
      busy_q   <= 1'b0;
      tflag_q  <= 1'b0;
`ifdef PIO_BERR_EN
      berr_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      region_q <= region_d;
      rw_q     <= rw_d;
      dtack_q  <= dtack_d;
      busy_q   <= busy_d;
      tflag_q  <= tflag_d;
`ifdef PIO_BERR_EN
      berr_q   <= berr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    region_d = region_q;
    rw_d     = rw_q;
    dtack_d  = dtack_q;
    tflag_d  = tflag_q;
`ifdef PIO_BERR_EN
    berr_d   = berr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cs && !bus.as_n) begin
          state_d  = ST_WAIT;
          count_d  = '0;
          region_d = bus.adm;
          rw_d     = bus.rw_n;
          tflag_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        // Address strobe release aborts silently; termination beats timeout.
        if (bus.as_n) begin
          state_d = ST_IDLE;
        end else if (term_c) begin
          state_d = ST_ACK;
          dtack_d = 1'b0;
        end else if (timeout_c) begin
          state_d = ST_ACK;
          tflag_d = 1'b1;
`ifdef PIO_BERR_EN
          berr_d  = 1'b0;
`else
          dtack_d = 1'b0;
`endif
        end else begin
          count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (bus.as_n) begin
          state_d = ST_IDLE;
          dtack_d = 1'b1;
`ifdef PIO_BERR_EN
          berr_d  = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.dtack_n      = dtack_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.cyc_rw_n     = rw_q;
`ifdef PIO_BERR_EN
  assign bus.berr_n       = berr_q;
`else
  assign bus.berr_n       = 1'b1;
`endif

endmodule

// File: tb/tb_pio_dtack_gen.sv
// Self-checking bench for pio_dtack_gen: cycle-level transaction model plus directed
// latency checks, followed by randomized host traffic.
module tb_pio_dtack_gen;

  localparam int WS_R0 = 1, WS_R1 = 3, WS_R3 = 0, USB_SETUP = 2, TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  pio_dtack_gen_if bus();

  pio_dtack_gen dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  bit         m_busy, m_dt, m_be, m_tflag, m_rw;
  int         m_elapsed;
  logic [2:0] m_reg;

  // Wait cycles a region needs before it may acknowledge; -1 when no fixed count applies.
  function automatic int fixed_wait(input logic [2:0] r);
    case (r)
      3'd0: return WS_R0;
      3'd1: return WS_R1;
      3'd3: return WS_R3;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_dt = 0; m_be = 0; m_tflag = 0; m_rw = 1; m_elapsed = 0; m_reg = 0;
    end else if (!m_busy) begin
      if (bus.cs && !bus.as_n) begin
        m_busy = 1; m_elapsed = 0; m_reg = bus.adm; m_rw = bus.rw_n; m_tflag = 0;
      end
    end else if (!m_dt && !m_be) begin
      if (bus.as_n) m_busy = 0;
      else begin
        bit done;
        done = (fixed_wait(m_reg) >= 0 && m_elapsed >= fixed_wait(m_reg)) ||
               (m_reg == 3'd2 && m_elapsed >= USB_SETUP && bus.usb_ready);
        if (done) m_dt = 1;
        else if (m_elapsed == TIMEOUT) begin
          m_tflag = 1;
`ifdef PIO_BERR_EN
          m_be = 1;
`else
          m_dt = 1;
`endif
        end else m_elapsed++;
      end
    end else if (bus.as_n) begin
      m_busy = 0; m_dt = 0; m_be = 0;
    end
  end

  always @(negedge clk) begin
    chk("dtack_n", int'(bus.dtack_n), int'(!m_dt));
    chk("berr_n", int'(bus.berr_n), int'(!m_be));
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("timeout_flag", int'(bus.timeout_flag), int'(m_tflag));
    chk("cyc_rw_n", int'(bus.cyc_rw_n), int'(m_rw));
  end

  // ---------------- stimulus helpers ----------------
  // One complete host access; lat = index of the edge after which the ack was seen.
  task automatic run_cycle(input logic [2:0] r, input logic rw, input int usb_at,
                           input int hold, output int lat, output bit saw_dt, output bit saw_be);
    int k; bit seen;
    bus.cs = 1; bus.as_n = 0; bus.adm = r; bus.rw_n = rw; bus.usb_ready = (usb_at == 0);
    k = 0; seen = 0; lat = -1; saw_dt = 0; saw_be = 0;
    while (!seen && k < 300) begin
      @(posedge clk); #1; k++;
      if (k == 1) begin bus.cs = 0; bus.rw_n = ~rw; end
      if (!bus.dtack_n || !bus.berr_n) begin
        seen = 1; lat = k - 1; saw_dt = !bus.dtack_n; saw_be = !bus.berr_n;
      end else if (usb_at > 0 && k == usb_at) bus.usb_ready = 1;
    end
    chk("ack_seen_in_budget", int'(seen), 1);
    repeat (hold) begin @(posedge clk); #1; end
    bus.as_n = 1; bus.usb_ready = 0;
    @(posedge clk); #1;
  endtask

  int lat; bit sdt, sbe;

  initial begin
    reset_n = 0;
    bus.cs = 0; bus.as_n = 1; bus.rw_n = 1; bus.adm = 3'd0; bus.usb_ready = 0;
    repeat (3) @(posedge clk); #1;
    chk("reset_dtack", int'(bus.dtack_n), 1);
    chk("reset_berr", int'(bus.berr_n), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_tflag", int'(bus.timeout_flag), 0);
    reset_n = 1;
    @(posedge clk); #1;

    // Region 0 write: ack after edge 2, held while as_n low, released on as_n high.
    run_cycle(3'd0, 1'b0, -1, 3, lat, sdt, sbe);
    chk("r0_latency", lat, 2);
    chk("r0_dtack", int'(sdt), 1);
    chk("r0_release_dtack", int'(bus.dtack_n), 1);
    chk("r0_release_busy", int'(bus.busy), 0);
    chk("r0_rw_latched", int'(bus.cyc_rw_n), 0);

    // Region 1 read then region 3 read with one idle cycle between.
    run_cycle(3'd1, 1'b1, -1, 1, lat, sdt, sbe);
    chk("r1_latency", lat, 4);
    run_cycle(3'd3, 1'b1, -1, 0, lat, sdt, sbe);
    chk("r3_latency", lat, 1);

    // Region 2: usb_ready low for 10 cycles, sampled high at edge 10.
    run_cycle(3'd2, 1'b1, 10, 1, lat, sdt, sbe);
    chk("r2_latency", lat, 10);
    chk("r2_tflag", int'(bus.timeout_flag), 0);

    // Region 5: only a timeout can end it.
    run_cycle(3'd5, 1'b1, -1, 2, lat, sdt, sbe);
    chk("r5_latency", lat, TIMEOUT + 1);
`ifdef PIO_BERR_EN
    chk("r5_berr", int'(sbe), 1);
    chk("r5_no_dtack", int'(sdt), 0);
`else
    chk("r5_dtack", int'(sdt), 1);
    chk("r5_no_berr", int'(sbe), 0);
`endif
    chk("r5_tflag_sticky", int'(bus.timeout_flag), 1);
    run_cycle(3'd0, 1'b1, -1, 0, lat, sdt, sbe);
    chk("tflag_cleared", int'(bus.timeout_flag), 0);

    // Abort: as_n rises at count 1.
    bus.cs = 1; bus.as_n = 0; bus.adm = 3'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.as_n = 1; bus.cs = 0;
    @(posedge clk); #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_dtack", int'(bus.dtack_n), 1);
    chk("abort_berr", int'(bus.berr_n), 1);
    @(posedge clk); #1;
    run_cycle(3'd0, 1'b0, -1, 1, lat, sdt, sbe);
    chk("post_abort_latency", lat, 2);

    // Reset mid-WAIT, then a normal cycle.
    bus.cs = 1; bus.as_n = 0; bus.adm = 3'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 0; bus.as_n = 1; bus.cs = 0;
    #1 chk("rst_wait_busy", int'(bus.busy), 0);
    #2 reset_n = 1;
    @(posedge clk); #1;
    run_cycle(3'd0, 1'b1, -1, 0, lat, sdt, sbe);
    chk("post_rst_latency", lat, 2);

    // Reset mid-ACK clears DTACK without a clock edge.
    bus.cs = 1; bus.as_n = 0; bus.adm = 3'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_dtack", int'(bus.dtack_n), 0);
    reset_n = 0;
    #1;
    chk("rst_ack_dtack", int'(bus.dtack_n), 1);
    chk("rst_ack_busy", int'(bus.busy), 0);
    bus.as_n = 1; bus.cs = 0;
    #1 reset_n = 1;
    @(posedge clk); #1;

    // Random host traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = (i < 1500) ? 8 : 90;
      bus.cs        = ($urandom % 4) != 0;
      bus.rw_n      = 1'($urandom % 2);
      bus.adm       = 3'($urandom % 8);
      bus.usb_ready = ($urandom % 4) == 0;
      if (!bus.as_n) bus.as_n = ($urandom % p) == 0;
      else           bus.as_n = ($urandom % 2) == 0;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
